// File: rtl/bids_nway_if.sv
// Bidder and host-control signal bundle for the N-way auction controller.
// The slave side is the controller; the master side is whoever drives the bids and ops.
interface bids_nway_if #(
    parameter int NUM_BIDDERS = 4,
    parameter int AMT_W       = 16,
    parameter int BAL_W       = 32
);
    logic [NUM_BIDDERS*AMT_W-1:0] bid_amt;
    logic [NUM_BIDDERS-1:0]       bid;
    logic [NUM_BIDDERS-1:0]       retract;
    logic [31:0]                  C_data;
    logic [3:0]                   C_op;
    logic                         C_start;
    logic [NUM_BIDDERS-1:0]       ack;
    logic [2*NUM_BIDDERS-1:0]     bid_err;
    logic [NUM_BIDDERS*BAL_W-1:0] balance;
    logic [NUM_BIDDERS-1:0]       win;
    logic                         ready;
    logic [2:0]                   err;
    logic                         roundOver;
    logic [AMT_W-1:0]             maxBid;

    modport master (
        output bid_amt, bid, retract, C_data, C_op, C_start,
        input  ack, bid_err, balance, win, ready, err, roundOver, maxBid
    );

    modport slave (
        input  bid_amt, bid, retract, C_data, C_op, C_start,
        output ack, bid_err, balance, win, ready, err, roundOver, maxBid
    );
endinterface

// File: rtl/bids_nway_ctrl.sv
// N-bidder auction controller: host-configured rounds with masking, fees, timeout and leader retract.
//  state    | meaning
//  UNLOCKED | configuration ops accepted, ready=1
//  LOCKED   | config frozen, waiting for C_start or Unlock, ready=1
//  ACTIVE   | round running, bids/retracts resolved every cycle
//  OVER     | single settlement cycle, roundOver/win asserted, then LOCKED
module bids_nway_ctrl #(
    parameter int          NUM_BIDDERS = 4,
    parameter int          AMT_W       = 16,
    parameter int          BAL_W       = 32,
    parameter int          TIMER_W     = 16,
    parameter int unsigned DEFAULT_BAL = 1000
) (
    input logic        clk,
    input logic        reset_n,
    bids_nway_if.slave bus
);
    localparam int N  = NUM_BIDDERS;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {S_UNLOCKED, S_LOCKED, S_ACTIVE, S_OVER} state_t;

    state_t             state;
    logic [31:0]        key;
    logic [N-1:0]       mask;
    logic [TIMER_W-1:0] timer_cfg;
    logic [TIMER_W-1:0] timer;
    logic [AMT_W-1:0]   fee;
    logic [IW-1:0]      sel;
    logic [BAL_W-1:0]   balance [N];
    logic               leader_vld;
    logic [IW-1:0]      leader;
    logic [AMT_W-1:0]   max_bid;
    logic [N-1:0]       ack_q;
    logic [2*N-1:0]     bid_err_q;
    logic [N-1:0]       win_q;
    logic               ready_q;
    logic [2:0]         err_q;
    logic               round_over_q;

    logic [AMT_W-1:0]   amt [N];
    logic               is_active;
    logic               ldr_retract;
    logic [AMT_W-1:0]   eff_max;
    logic [N-1:0]       valid;
    logic               best_found;
    logic [IW-1:0]      best_idx;
    logic [AMT_W-1:0]   best_amt;
    logic [2*N-1:0]     bid_err_n;
    logic               nxt_vld;
    logic [IW-1:0]      nxt_ldr;
    logic [AMT_W-1:0]   nxt_max;
    logic               end_round;
    logic [N-1:0]       win_next;
    logic [BAL_W-1:0]   bal_next [N];
    logic [N*BAL_W-1:0] bal_flat;

    // Ops other than no-op are illegal outside their home state; 8..15 are never legal.
    function automatic logic [2:0] op_fault(input logic [3:0] op);
        if (op == 4'd0)
            return 3'd0;
        else if (op >= 4'd8)
            return 3'd5;
        else
            return 3'd1;
    endfunction

    always_comb begin
        is_active = (state == S_ACTIVE);
        for (int i = 0; i < N; i++)
            amt[i] = bus.bid_amt[i*AMT_W +: AMT_W];

        // A leader retract clears the standing bid before this cycle's bids are compared.
        ldr_retract = is_active && leader_vld && bus.retract[leader] && !bus.bid[leader];
        eff_max     = ldr_retract ? '0 : max_bid;

        valid      = '0;
        best_found = 1'b0;
        best_idx   = '0;
        best_amt   = '0;
        bid_err_n  = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.bid[i]) begin
                if (!is_active || !mask[i])
                    bid_err_n[2*i +: 2] = 2'b01;
                else if (amt[i] <= eff_max)
                    bid_err_n[2*i +: 2] = 2'b11;
                else if (balance[i] < (BAL_W'(fee) + BAL_W'(amt[i])))
                    bid_err_n[2*i +: 2] = 2'b10;
                else
                    valid[i] = 1'b1;
            end else if (bus.retract[i]) begin
                if (!is_active)
                    bid_err_n[2*i +: 2] = 2'b01;
                else if (!(leader_vld && leader == IW'(i)))
                    bid_err_n[2*i +: 2] = 2'b11;
            end
        end

        // Strict compare keeps the lowest index on ties.
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (!best_found || amt[i] > best_amt)) begin
                best_found = 1'b1;
                best_idx   = IW'(i);
                best_amt   = amt[i];
            end
        end
        for (int i = 0; i < N; i++)
            if (valid[i] && best_idx != IW'(i))
                bid_err_n[2*i +: 2] = 2'b11;

        nxt_vld = leader_vld;
        nxt_ldr = leader;
        nxt_max = max_bid;
        if (ldr_retract) begin
            nxt_vld = 1'b0;
            nxt_ldr = '0;
            nxt_max = '0;
        end
        if (best_found) begin
            nxt_vld = 1'b1;
            nxt_ldr = best_idx;
            nxt_max = best_amt;
        end

        end_round = is_active && (!bus.C_start || (timer_cfg != '0 && timer == TIMER_W'(1)));

        win_next = '0;
        if (nxt_vld)
            win_next[nxt_ldr] = 1'b1;

        // Settlement uses the leader after this cycle's bids, so last-cycle bids still count.
        for (int i = 0; i < N; i++) begin
            bal_next[i] = balance[i];
            if (valid[i])
                bal_next[i] = bal_next[i] - BAL_W'(fee);
            if (end_round && nxt_vld && nxt_ldr == IW'(i))
                bal_next[i] = bal_next[i] - BAL_W'(nxt_max);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_UNLOCKED;
            key          <= '0;
            mask         <= '1;
            timer_cfg    <= '0;
            timer        <= '0;
            fee          <= '0;
            sel          <= '0;
            for (int i = 0; i < N; i++)
                balance[i] <= BAL_W'(DEFAULT_BAL);
            leader_vld   <= 1'b0;
            leader       <= '0;
            max_bid      <= '0;
            ack_q        <= '0;
            bid_err_q    <= '0;
            win_q        <= '0;
            ready_q      <= 1'b1;
            err_q        <= '0;
            round_over_q <= 1'b0;
        end else begin
            ack_q        <= bus.bid | bus.retract;
            bid_err_q    <= bid_err_n;
            err_q        <= '0;
            round_over_q <= 1'b0;
            case (state)
                S_UNLOCKED: begin
                    if (bus.C_start)
                        err_q <= 3'd3;
                    case (bus.C_op)
                        4'd0: begin end
                        4'd1: err_q <= 3'd1;
                        4'd2: begin
                            key   <= bus.C_data;
                            state <= S_LOCKED;
                        end
                        4'd3: begin
                            if (bus.C_data < 32'(N))
                                sel <= bus.C_data[IW-1:0];
                            else
                                err_q <= 3'd4;
                        end
                        4'd4: balance[sel] <= BAL_W'(bus.C_data);
                        4'd5: mask         <= bus.C_data[N-1:0];
                        4'd6: timer_cfg    <= bus.C_data[TIMER_W-1:0];
                        4'd7: fee          <= bus.C_data[AMT_W-1:0];
                        default: err_q <= 3'd5;
                    endcase
                end
                S_LOCKED: begin
                    // A valid Unlock takes priority over a simultaneous start request.
                    if (bus.C_op == 4'd1) begin
                        if (bus.C_data == key)
                            state <= S_UNLOCKED;
                        else
                            err_q <= 3'd2;
                    end else begin
                        err_q <= op_fault(bus.C_op);
                        if (bus.C_start) begin
                            if (mask == '0) begin
                                err_q <= 3'd3;
                            end else begin
                                state      <= S_ACTIVE;
                                ready_q    <= 1'b0;
                                max_bid    <= '0;
                                leader_vld <= 1'b0;
                                leader     <= '0;
                                win_q      <= '0;
                                timer      <= timer_cfg;
                            end
                        end
                    end
                end
                S_ACTIVE: begin
                    err_q <= op_fault(bus.C_op);
                    for (int i = 0; i < N; i++)
                        balance[i] <= bal_next[i];
                    leader_vld <= nxt_vld;
                    leader     <= nxt_ldr;
                    max_bid    <= nxt_max;
                    if (timer_cfg != '0)
                        timer <= timer - TIMER_W'(1);
                    if (end_round) begin
                        state        <= S_OVER;
                        round_over_q <= 1'b1;
                        win_q        <= win_next;
                    end
                end
                S_OVER: begin
                    err_q   <= op_fault(bus.C_op);
                    state   <= S_LOCKED;
                    ready_q <= 1'b1;
                end
                default: state <= S_UNLOCKED;
            endcase
        end
    end

    always_comb begin
        bal_flat = '0;
        for (int i = 0; i < N; i++)
            bal_flat[i*BAL_W +: BAL_W] = balance[i];
    end

    assign bus.ack       = ack_q;
    assign bus.bid_err   = bid_err_q;
    assign bus.balance   = bal_flat;
    assign bus.win       = win_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.roundOver = round_over_q;
    assign bus.maxBid    = max_bid;

endmodule

// File: tb/tb_bids_nway_ctrl.sv
// Directed and randomized checks of the 4-bidder auction controller against an abstract model.
module tb_bids_nway_ctrl;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    bids_nway_if #(.NUM_BIDDERS(4), .AMT_W(16), .BAL_W(32)) bus ();

    bids_nway_ctrl #(
        .NUM_BIDDERS(4), .AMT_W(16), .BAL_W(32), .TIMER_W(16), .DEFAULT_BAL(1000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int       m_bal [4];
    int       m_max;
    int       m_ldr;
    bit [3:0] m_mask;
    int       m_fee;
    bit       r_bid [4];
    bit       r_ret [4];
    int       r_amt [4];
    logic [7:0]   e_err;
    logic [3:0]   e_ack;
    logic [3:0]   e_win;
    logic [127:0] e_bal;
    int       n;
    bit       last;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] data);
        bus.C_op   = op;
        bus.C_data = data;
        tick();
        bus.C_op   = 4'd0;
        bus.C_data = '0;
    endtask

    function automatic logic [127:0] bal4(input int b3, input int b2, input int b1, input int b0);
        return {32'(b3), 32'(b2), 32'(b1), 32'(b0)};
    endfunction

    // One auction cycle from the rules: retract first, then admission, then the highest valid bid.
    task automatic model_step(input bit fin);
        int  eff;
        int  best;
        int  old_ldr;
        bit  cand [4];
        old_ldr = m_ldr;
        eff = m_max;
        if (m_ldr >= 0 && r_ret[m_ldr] && !r_bid[m_ldr]) begin
            eff   = 0;
            m_ldr = -1;
            m_max = 0;
        end
        best  = -1;
        e_err = '0;
        e_ack = '0;
        for (int i = 0; i < 4; i++) begin
            cand[i]  = 1'b0;
            e_ack[i] = r_bid[i] | r_ret[i];
            if (r_bid[i]) begin
                if (!m_mask[i])                      e_err[2*i +: 2] = 2'b01;
                else if (r_amt[i] <= eff)            e_err[2*i +: 2] = 2'b11;
                else if (m_bal[i] < m_fee + r_amt[i]) e_err[2*i +: 2] = 2'b10;
                else begin
                    cand[i] = 1'b1;
                    if (best < 0 || r_amt[i] > r_amt[best]) best = i;
                end
            end else if (r_ret[i]) begin
                e_err[2*i +: 2] = (i == old_ldr) ? 2'b00 : 2'b11;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
                m_bal[i] -= m_fee;
                if (i != best) e_err[2*i +: 2] = 2'b11;
            end
        end
        if (best >= 0) begin
            m_ldr = best;
            m_max = r_amt[best];
        end
        e_win = '0;
        if (fin && m_ldr >= 0) begin
            m_bal[m_ldr] -= m_max;
            e_win[m_ldr] = 1'b1;
        end
        e_bal = bal4(m_bal[3], m_bal[2], m_bal[1], m_bal[0]);
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.bid_amt = '0;
        bus.bid     = '0;
        bus.retract = '0;
        bus.C_data  = '0;
        bus.C_op    = 4'd0;
        bus.C_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("rst_ready", bus.ready, 1);
        check("rst_maxbid", bus.maxBid, 0);
        check("rst_win", bus.win, 0);
        check("rst_err", bus.err, 0);
        check("rst_round_over", bus.roundOver, 0);
        check("rst_balance", bus.balance, bal4(1000, 1000, 1000, 1000));

        // Control-path errors and lock/unlock
        bus.C_start = 1'b1;
        tick();
        bus.C_start = 1'b0;
        check("start_unlocked", bus.err, 3);
        do_op(4'd9, 0);
        check("bad_opcode", bus.err, 5);
        do_op(4'd1, 0);
        check("unlock_in_unlocked", bus.err, 1);
        do_op(4'd2, 32'hA5A5);
        check("lock_err", bus.err, 0);
        check("lock_ready", bus.ready, 1);
        do_op(4'd1, 32'h1234);
        check("wrong_key", bus.err, 2);
        do_op(4'd3, 0);
        check("setsel_locked", bus.err, 1);
        do_op(4'd1, 32'hA5A5);
        check("right_key", bus.err, 0);
        do_op(4'd3, 9);
        check("setsel_range", bus.err, 4);
        do_op(4'd3, 3);
        do_op(4'd4, 10);
        check("loadbal", bus.balance, bal4(10, 1000, 1000, 1000));
        do_op(4'd7, 5);
        do_op(4'd2, 1);

        // Directed round
        bus.C_start = 1'b1;
        tick();
        check("active_ready", bus.ready, 0);
        check("active_maxbid", bus.maxBid, 0);
        bus.bid = 4'b1000;
        bus.bid_amt[3*16 +: 16] = 16'd20;
        tick();
        bus.bid = '0;
        check("funds_ack", bus.ack, 4'b1000);
        check("funds_err", bus.bid_err, 8'b10_00_00_00);
        bus.bid = 4'b0101;
        bus.bid_amt = '0;
        bus.bid_amt[0*16 +: 16] = 16'd100;
        bus.bid_amt[2*16 +: 16] = 16'd100;
        tick();
        bus.bid = '0;
        check("tie_ack", bus.ack, 4'b0101);
        check("tie_err", bus.bid_err, 8'b00_11_00_00);
        check("tie_balance", bus.balance, bal4(10, 995, 1000, 995));
        check("tie_maxbid", bus.maxBid, 100);
        bus.retract = 4'b0001;
        bus.bid = 4'b0010;
        bus.bid_amt = '0;
        bus.bid_amt[1*16 +: 16] = 16'd50;
        tick();
        bus.retract = '0;
        bus.bid = '0;
        check("retract_ack", bus.ack, 4'b0011);
        check("retract_err", bus.bid_err, 0);
        check("retract_maxbid", bus.maxBid, 50);
        check("retract_balance", bus.balance, bal4(10, 995, 995, 995));
        bus.C_start = 1'b0;
        tick();
        check("end_round_over", bus.roundOver, 1);
        check("end_win", bus.win, 4'b0010);
        check("end_balance", bus.balance, bal4(10, 995, 945, 995));
        tick();
        check("after_round_over", bus.roundOver, 0);
        check("after_ready", bus.ready, 1);
        check("after_win_held", bus.win, 4'b0010);
        check("after_maxbid_held", bus.maxBid, 50);
        bus.bid = 4'b0001;
        tick();
        bus.bid = '0;
        check("bid_locked_err", bus.bid_err, 8'b00_00_00_01);

        // Timeout round
        do_op(4'd1, 1);
        do_op(4'd6, 3);
        do_op(4'd2, 1);
        bus.C_start = 1'b1;
        tick();
        check("timer_active", bus.ready, 0);
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (bus.roundOver) break;
        end
        bus.C_start = 1'b0;
        check("timer_latency", n, 3);
        check("timer_no_winner", bus.win, 0);
        tick();
        check("timer_back_locked", bus.ready, 1);

        // Empty mask refuses to start
        do_op(4'd1, 1);
        do_op(4'd5, 0);
        do_op(4'd2, 1);
        bus.C_start = 1'b1;
        tick();
        bus.C_start = 1'b0;
        check("mask0_err", bus.err, 3);
        check("mask0_ready", bus.ready, 1);
        do_op(4'd1, 1);
        do_op(4'd5, 32'hF);
        do_op(4'd6, 0);
        do_op(4'd2, 1);

        // Reset in the middle of a round
        bus.C_start = 1'b1;
        tick();
        bus.bid = 4'b0001;
        bus.bid_amt = '0;
        bus.bid_amt[0*16 +: 16] = 16'd100;
        tick();
        bus.bid = '0;
        bus.C_start = 1'b0;
        check("pre_reset_maxbid", bus.maxBid, 100);
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        check("midrst_balance", bus.balance, bal4(1000, 1000, 1000, 1000));
        check("midrst_ready", bus.ready, 1);
        check("midrst_win", bus.win, 0);
        check("midrst_maxbid", bus.maxBid, 0);

        // Randomized round against the model
        do_op(4'd7, 3);
        do_op(4'd5, 32'b1011);
        do_op(4'd3, 3);
        do_op(4'd4, 60);
        do_op(4'd2, 7);
        m_bal[0] = 1000; m_bal[1] = 1000; m_bal[2] = 1000; m_bal[3] = 60;
        m_max = 0; m_ldr = -1; m_mask = 4'b1011; m_fee = 3;
        bus.C_start = 1'b1;
        tick();
        for (int cyc = 0; cyc < 60; cyc++) begin
            last = (cyc == 59);
            for (int i = 0; i < 4; i++) begin
                r_bid[i] = ($urandom_range(0, 2) == 0);
                r_ret[i] = ($urandom_range(0, 7) == 0);
                r_amt[i] = int'($urandom_range(0, 400));
                bus.bid[i] = r_bid[i];
                bus.retract[i] = r_ret[i];
                bus.bid_amt[i*16 +: 16] = 16'(r_amt[i]);
            end
            bus.C_start = !last;
            tick();
            model_step(last);
            check("rnd_ack", bus.ack, e_ack);
            check("rnd_bid_err", bus.bid_err, e_err);
            check("rnd_maxbid", bus.maxBid, 16'(m_max));
            check("rnd_balance", bus.balance, e_bal);
            check("rnd_round_over", bus.roundOver, last);
            check("rnd_win", bus.win, e_win);
        end
        bus.bid = '0;
        bus.retract = '0;
        tick();
        check("rnd_final_ready", bus.ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
